// File: rtl/blink_rate_ctrl.sv
// -----------------------------------------------------------------------------
// blink_rate_ctrl
//
// Front-end control stage for the board LED blinker. It cleans up the raw
// push button, steps through four blink rates (one step per accepted press)
// and produces a one-cycle TICK clock-enable at the selected rate. The LED
// toggling stage uses TICK in place of its own free-running compare.
//
// Ports:
//   CLOCK_50  in   1  system clock, every flop is on its rising edge
//   RESET_N   in   1  asynchronous active-low reset
//   KEY_N     in   1  raw button, active low (0 = pressed), asynchronous
//   TICK      out  1  one-cycle pulse every PERIOD[RATE_SEL] cycles
//   RATE_SEL  out  2  current rate index 0..3
//   PRESS     out  1  one-cycle pulse per accepted press
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a level change counts
//   PERIOD0..3       TICK period in cycles for rates 0..3
//   CNT_W            prescaler width, must hold max(PERIODn)-1
//   DB_W             debounce counter width, must hold DEBOUNCE_CYCLES-1
// -----------------------------------------------------------------------------
module blink_rate_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned PERIOD0         = 25000000,
   parameter int unsigned PERIOD1         = 12500000,
   parameter int unsigned PERIOD2         = 6250000,
   parameter int unsigned PERIOD3         = 3125000,
   parameter int unsigned CNT_W           = 25,
   parameter int unsigned DB_W            = 19
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       KEY_N,
   output logic       TICK,
   output logic [1:0] RATE_SEL,
   output logic       PRESS
);

   // Rate states; the encoding is exactly the RATE_SEL value.
   typedef enum logic [1:0] {
      R0 = 2'd0,
      R1 = 2'd1,
      R2 = 2'd2,
      R3 = 2'd3
   } rate_e;

   // Terminal counts, precomputed at the counter widths so the compares
   // below are plain equality tests.
   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] P0_LAST = CNT_W'(PERIOD0 - 1);
   localparam logic [CNT_W-1:0] P1_LAST = CNT_W'(PERIOD1 - 1);
   localparam logic [CNT_W-1:0] P2_LAST = CNT_W'(PERIOD2 - 1);
   localparam logic [CNT_W-1:0] P3_LAST = CNT_W'(PERIOD3 - 1);

   // Synchronizer
   logic keyMeta_q;
   logic keySync_q;

   // Debouncer
   logic            stable_q;
   logic            stable_d;
   logic [DB_W-1:0] dbCount_q;
   logic [DB_W-1:0] dbCount_d;

   // Press detection
   logic stableDly_q;
   logic pressEdge;
   logic press_q;

   // Rate state machine
   rate_e rate_q;
   rate_e rate_d;

   // Prescaler
   logic [CNT_W-1:0] prescale_q;
   logic [CNT_W-1:0] prescale_d;
   logic [CNT_W-1:0] periodLast;
   logic             tick_q;
   logic             tick_d;

   // -------------------------------------------------------------------------
   // Two-flop synchronizer for the asynchronous button. Both flops reset to
   // the released level so a reset never looks like a press by itself; a
   // button that really is held through reset is then seen as a normal
   // 1 -> 0 change once the debouncer accepts it.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         keyMeta_q <= 1'b1;
         keySync_q <= 1'b1;
      end else begin
         keyMeta_q <= KEY_N;
         keySync_q <= keyMeta_q;
      end
   end

   // -------------------------------------------------------------------------
   // Debounce next-state. The counter only runs while the synchronized level
   // disagrees with the accepted level; any cycle of agreement throws the
   // partial count away. When the count reaches its terminal value the new
   // level is taken, which happens after DEBOUNCE_CYCLES consecutive
   // mismatching cycles.
   // -------------------------------------------------------------------------
   always_comb begin
      stable_d  = stable_q;
      dbCount_d = dbCount_q;
      if (keySync_q == stable_q) begin
         dbCount_d = '0;
      end else if (dbCount_q == DB_LAST) begin
         stable_d  = keySync_q;
         dbCount_d = '0;
      end else begin
         dbCount_d = dbCount_q + DB_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Debounce state registers. The accepted level resets to released.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         stable_q  <= 1'b1;
         dbCount_q <= '0;
      end else begin
         stable_q  <= stable_d;
         dbCount_q <= dbCount_d;
      end
   end

   // -------------------------------------------------------------------------
   // Falling-edge detect on the debounced level. pressEdge is high during the
   // cycle right after stable drops; the same edge that registers it into
   // PRESS also advances the rate and restarts the prescaler, so all three
   // effects of a press line up on one clock edge. Releases are ignored.
   // -------------------------------------------------------------------------
   assign pressEdge = stableDly_q & ~stable_q;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         stableDly_q <= 1'b1;
         press_q     <= 1'b0;
      end else begin
         stableDly_q <= stable_q;
         press_q     <= pressEdge;
      end
   end

   // -------------------------------------------------------------------------
   // Rate state register.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         rate_q <= R0;
      end else begin
         rate_q <= rate_d;
      end
   end

   // -------------------------------------------------------------------------
   // Rate next-state: each accepted press steps R0 -> R1 -> R2 -> R3 and
   // wraps back to R0.
   // -------------------------------------------------------------------------
   always_comb begin
      rate_d = rate_q;
      if (pressEdge) begin
         unique case (rate_q)
            R0: rate_d = R1;
            R1: rate_d = R2;
            R2: rate_d = R3;
            R3: rate_d = R0;
            default: rate_d = R0;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Terminal count of the prescaler for the rate currently in force.
   // -------------------------------------------------------------------------
   always_comb begin
      periodLast = P0_LAST;
      unique case (rate_q)
         R0: periodLast = P0_LAST;
         R1: periodLast = P1_LAST;
         R2: periodLast = P2_LAST;
         R3: periodLast = P3_LAST;
         default: periodLast = P0_LAST;
      endcase
   end

   // -------------------------------------------------------------------------
   // Prescaler next-state. The counter wraps at the terminal count and fires
   // TICK on that edge. A rate change takes priority: the counter restarts
   // from zero and TICK is held low even if this was the terminal count, so
   // the first tick at the new rate lands a full new period after the press.
   // -------------------------------------------------------------------------
   always_comb begin
      prescale_d = prescale_q + CNT_W'(1);
      tick_d     = 1'b0;
      if (pressEdge) begin
         prescale_d = '0;
      end else if (prescale_q == periodLast) begin
         prescale_d = '0;
         tick_d     = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Prescaler and TICK registers.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         prescale_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         prescale_q <= prescale_d;
         tick_q     <= tick_d;
      end
   end

   assign TICK     = tick_q;
   assign PRESS    = press_q;
   assign RATE_SEL = rate_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_blink_rate_ctrl
//
// Directed and randomized checks of blink_rate_ctrl with a short debounce
// (4 cycles) and periods 8, 4, 3, 2. The reference model works on the raw
// button history: the accepted level flips when the last DEBOUNCE_CYCLES
// synchronized samples all disagree with it, a press is reported one cycle
// after a 1 -> 0 flip, and TICK fires whenever a whole number of periods has
// elapsed since the last restart (reset release or rate change).
// -----------------------------------------------------------------------------
module tb_blink_rate_ctrl;

   localparam int DEB = 4;

   logic       CLOCK_50;
   logic       RESET_N;
   logic       KEY_N;
   logic       TICK;
   logic [1:0] RATE_SEL;
   logic       PRESS;

   int testCount = 0;
   int failCount = 0;

   // Reference model state
   int periods [4] = '{8, 4, 3, 2};
   bit samp [$];
   bit mStable;
   bit mFellLast;
   int mRate;
   int mEdge;
   int mRestart;
   bit expTick;
   bit expPress;

   blink_rate_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .PERIOD0         (8),
      .PERIOD1         (4),
      .PERIOD2         (3),
      .PERIOD3         (2),
      .CNT_W           (4),
      .DB_W            (3)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .KEY_N    (KEY_N),
      .TICK     (TICK),
      .RATE_SEL (RATE_SEL),
      .PRESS    (PRESS)
   );

   // Free-running 100 MHz-style clock (10 time units per period).
   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   // Model state as it is right after reset: the synchronizer and accepted
   // level all look released, so the history is filled with ones.
   task automatic modelReset();
      samp = {};
      for (int i = 0; i < DEB + 2; i++) samp.push_front(1'b1);
      mStable   = 1'b1;
      mFellLast = 1'b0;
      mRate     = 0;
      mEdge     = 0;
      mRestart  = 0;
      expTick   = 1'b0;
      expPress  = 1'b0;
   endtask

   // Advance the model by one rising edge on which KEY_N was k. samp[0] is
   // the newest sample; the synchronized value seen at this edge is the key
   // from two edges back, so the debounce window is samp[1..DEB].
   task automatic modelEdge(input bit k);
      bit allDiff;
      bit fellNow;
      mEdge++;
      allDiff = 1'b1;
      for (int i = 1; i <= DEB; i++) begin
         if (samp[i] == mStable) allDiff = 1'b0;
      end
      fellNow = 1'b0;
      if (allDiff) begin
         mStable = ~mStable;
         fellNow = (mStable == 1'b0);
      end
      samp.push_front(k);
      void'(samp.pop_back());
      expPress = mFellLast;
      if (mFellLast) begin
         mRate    = (mRate + 1) % 4;
         mRestart = mEdge;
         expTick  = 1'b0;
      end else begin
         expTick = ((mEdge - mRestart) % periods[mRate]) == 0;
      end
      mFellLast = fellNow;
   endtask

   // Compare all three outputs against the model.
   task automatic checkOutput(input string tag);
      testCount++;
      assert (TICK === expTick) else begin
         failCount++;
         $error("[TB] FAIL %s tick edge %0d: observed %b expected %b", tag, mEdge, TICK, expTick);
      end
      testCount++;
      assert (PRESS === expPress) else begin
         failCount++;
         $error("[TB] FAIL %s press edge %0d: observed %b expected %b", tag, mEdge, PRESS, expPress);
      end
      testCount++;
      assert (RATE_SEL === 2'(mRate)) else begin
         failCount++;
         $error("[TB] FAIL %s rate edge %0d: observed %0d expected %0d", tag, mEdge, RATE_SEL, mRate);
      end
   endtask

   // Drive one cycle of button level, let the edge happen, then check.
   task automatic applyStimulus(input bit k, input string tag);
      KEY_N = k;
      @(posedge CLOCK_50);
      modelEdge(k);
      #1;
      checkOutput(tag);
   endtask

   // Pull reset between clock edges, confirm outputs clear without a clock
   // edge, hold for a few edges, then release away from the edge.
   task automatic pulseReset(input bit keyDuring, input string tag);
      #2;
      RESET_N = 1'b0;
      KEY_N   = keyDuring;
      #1;
      modelReset();
      checkOutput(tag);
      repeat (3) @(posedge CLOCK_50);
      #1;
      checkOutput(tag);
      RESET_N = 1'b1;
   endtask

   initial begin
      bit lvl;
      int len;

      RESET_N = 1'b0;
      KEY_N   = 1'b1;
      modelReset();
      repeat (2) @(posedge CLOCK_50);
      #1;
      checkOutput("reset");
      RESET_N = 1'b1;

      // 1: idle after reset, ticks at edges 8, 16, 24
      repeat (26) applyStimulus(1'b1, "idle");

      // 2: short glitch is discarded
      repeat (3) applyStimulus(1'b0, "glitch");
      repeat (15) applyStimulus(1'b1, "glitch");

      // 3: bouncy press and bouncy release give one press
      applyStimulus(1'b0, "bounce");
      applyStimulus(1'b1, "bounce");
      applyStimulus(1'b0, "bounce");
      applyStimulus(1'b1, "bounce");
      repeat (18) applyStimulus(1'b0, "bounce");
      applyStimulus(1'b1, "bounce");
      applyStimulus(1'b0, "bounce");
      applyStimulus(1'b1, "bounce");
      applyStimulus(1'b0, "bounce");
      repeat (15) applyStimulus(1'b1, "bounce");

      // 4: four clean presses step the rate and wrap
      for (int p = 0; p < 4; p++) begin
         repeat (8) applyStimulus(1'b0, "clean");
         repeat (20) applyStimulus(1'b1, "clean");
      end

      // 5: reset mid-debounce and mid-prescale with a nonzero rate
      repeat (8) applyStimulus(1'b0, "midrst");
      repeat (9) applyStimulus(1'b1, "midrst");
      repeat (3) applyStimulus(1'b0, "midrst");
      pulseReset(1'b1, "midrst");
      repeat (26) applyStimulus(1'b1, "midrst");

      // 6: button held through reset release counts once
      pulseReset(1'b0, "heldrst");
      repeat (14) applyStimulus(1'b0, "heldrst");
      repeat (12) applyStimulus(1'b1, "heldrst");

      // Randomized button activity with bursts of random length
      for (int b = 0; b < 80; b++) begin
         lvl = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 10));
         repeat (len) applyStimulus(lvl, "random");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
